// File: rtl/alu_serial_if.sv
// alu_serial_if: request/result bundle for the bit-serial ALU.
// master drives the request side, slave returns status and flags.
interface alu_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             n;
    logic             z;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             ovf;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, f, cout, n, z, lt, eq, gt, ovf
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, f, cout, n, z, lt, eq, gt, ovf
    );
endinterface

// File: rtl/alu_serial.sv
// alu_serial: WIDTH-bit ALU through one 1-bit slice, LSB first.
// Optional signed overflow flag: define ALU_SERIAL_OVF_EN.
module alu_serial #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_serial_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_CMP = 2'b10;
    localparam logic [1:0] M_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_mode;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh;
    logic             r_zacc;
    logic             r_ltacc;
    logic             r_gtacc;

    logic [WIDTH-1:0] r_f;
    logic             r_cout;
    logic             r_n;
    logic             r_z;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_addsub;
    logic             w_cmp;
    logic             w_xor;
    logic             w_ai;
    logic             w_bi;
    logic             w_bp;
    logic             w_sum;
    logic             w_cn;
    logic             w_s;
    logic             w_diff;
    logic [WIDTH-1:0] w_sh_nxt;
    logic             w_z_nxt;
    logic             w_lt_nxt;
    logic             w_gt_nxt;
    logic             w_busy;
    logic             w_done;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = bus.start && !w_run;
    assign w_last   = w_run && (r_cnt == CW'(WIDTH - 1));

    assign w_addsub = (r_mode == M_ADD) || (r_mode == M_SUB);
    assign w_cmp    = (r_mode == M_CMP);
    assign w_xor    = (r_mode == M_XOR);

    assign w_ai     = r_a[0];
    assign w_bi     = r_b[0];
    assign w_bp     = (r_mode == M_SUB) ? ~w_bi : w_bi;
    assign w_sum    = w_ai ^ w_bp ^ r_c;
    assign w_cn     = (w_ai & w_bp) | (w_ai & r_c) | (w_bp & r_c);
    assign w_diff   = w_ai ^ w_bi;

    // Result bit of the slice for the captured operation
    always_comb begin
        w_s = 1'b0;
        unique case (1'b1)
            w_addsub: w_s = w_sum;
            w_cmp:    w_s = ~w_diff;
            w_xor:    w_s = w_diff;
            default:  w_s = 1'b0;
        endcase
    end

    assign w_sh_nxt = {w_s, r_sh[WIDTH-1:1]};
    assign w_z_nxt  = r_zacc & ~w_s;
    assign w_gt_nxt = w_diff ? w_ai : r_gtacc;
    assign w_lt_nxt = w_diff ? w_bi : r_ltacc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and per-bit slice state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= M_ADD;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_zacc  <= 1'b0;
            r_ltacc <= 1'b0;
            r_gtacc <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_mode  <= bus.mode;
            r_c     <= bus.cin;
            r_cnt   <= '0;
            r_zacc  <= 1'b1;
            r_ltacc <= 1'b0;
            r_gtacc <= 1'b0;
        end else if (w_run) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_c     <= w_cn;
            r_cnt   <= r_cnt + CW'(1);
            r_sh    <= w_sh_nxt;
            r_zacc  <= w_z_nxt;
            r_ltacc <= w_lt_nxt;
            r_gtacc <= w_gt_nxt;
        end
    end

    // Result and flag registers, loaded on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f    <= '0;
            r_cout <= 1'b0;
            r_n    <= 1'b0;
            r_z    <= 1'b0;
            r_lt   <= 1'b0;
            r_eq   <= 1'b0;
            r_gt   <= 1'b0;
        end else if (w_last) begin
            r_f    <= w_sh_nxt;
            r_cout <= w_addsub & w_cn;
            r_n    <= w_s;
            r_z    <= w_z_nxt;
            r_lt   <= w_cmp & w_lt_nxt;
            r_gt   <= w_cmp & w_gt_nxt;
            r_eq   <= w_cmp & ~w_lt_nxt & ~w_gt_nxt;
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_addsub & (r_c ^ w_cn);
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.f    = r_f;
    assign bus.cout = r_cout;
    assign bus.n    = r_n;
    assign bus.z    = r_z;
    assign bus.lt   = r_lt;
    assign bus.eq   = r_eq;
    assign bus.gt   = r_gt;
endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised bit-serial ALU processing WIDTH-bit operands one bit per clock, LSB first, through a single 1-bit add/compare slice, with a start/busy/done handshake. It generalises the combinational 1-bit ALU slice to arbitrary width at minimal area. It sits beside the 4-bit parallel ALU for area-constrained datapaths where multi-cycle latency is acceptable.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when state is not RUN.
- mode  in  2  operation: 00 ADD, 01 SUB, 10 CMP, 11 XOR.
- a  in  WIDTH  operand A; captured on an accepted start.
- b  in  WIDTH  operand B; captured on an accepted start.
- cin  in  1  carry-in for ADD/SUB; captured on an accepted start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse: result is valid.
- f  out  WIDTH  result; held until the next completion.
- cout  out  1  final carry (ADD/SUB); 0 otherwise.
- n  out  1  f[WIDTH-1].
- z  out  1  1 when f == 0.
- lt, eq, gt  out  1 each  unsigned A vs B (CMP only; 0 otherwise).
- ovf  out  1  signed overflow (see Configuration).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE with start=1: capture a, b, cin, and mode; clear the bit counter; state → RUN. With start=0: DONE → IDLE, IDLE stays.
- RUN: each cycle processes bit i = counter using a_i, b'_i (b'_i = ~b_i for SUB, else b_i) and carry c.
  - ADD/SUB: s = a_i ^ b'_i ^ c; c ← majority(a_i, b'_i, c). Initial c = cin.
  - XOR: s = a_i ^ b_i.
  - CMP: s = ~(a_i ^ b_i). If a_i ≠ b_i, running gt ← a_i, lt ← b_i (later bits override earlier ones, which gives unsigned order).
  - s shifts into the result shift register from the MSB end. A running zero-accumulator ANDs in ~s.
- On the last RUN cycle (counter == WIDTH-1), the registered outputs load: f, cout (final c for ADD/SUB, else 0), n, z, lt/eq/gt (eq = ~lt & ~gt; all 0 unless CMP), and ovf. State → DONE, done=1.
- start while RUN is ignored. Input changes during RUN have no effect.
- SUB with cin=1 yields A−B; cout=1 means no borrow.
- rst_n low at any time, including mid-RUN: the operation is abandoned immediately and all state and outputs are cleared.

## Timing
- Reset values: busy=0, done=0, f=0, cout=0, n=0, z=0, lt=0, eq=0, gt=0, ovf=0; state IDLE.
- Start sampled at edge k → busy=1 after edge k through edge k+WIDTH−1. Outputs update and done=1 after edge k+WIDTH. Latency is WIDTH cycles.
- done is high for exactly one cycle unless start is asserted in DONE. In that case done falls, busy rises, and the new operation starts the same edge (back-to-back throughput one result per WIDTH+1 cycles).
- Outputs change only at completion edges or reset.

## Configuration
- ALU_SERIAL_OVF_EN defined: ovf = (carry into bit WIDTH-1) XOR (carry out) for ADD/SUB, 0 for CMP/XOR. It is loaded with the other outputs.
- Not defined: ovf is tied to 0 and the MSB carry-in register is not built. The port remains present.

## Test plan
- WIDTH=8, ADD a=0x7F b=0x01 cin=0 → after 8 cycles done=1, f=0x80, cout=0, n=1, z=0, ovf=1 (macro on) / 0 (off).
- ADD a=0xFF b=0x01 cin=0 → f=0x00, cout=1, z=1, n=0, ovf=0. SUB a=0x05 b=0x05 cin=1 → f=0x00, cout=1, z=1.
- CMP a=0x80 b=0x7F → gt=1, lt=0, eq=0, f=0x00, z=1. CMP a=b=0x3C → eq=1, f=0xFF, cout=0.
- XOR a=0xF0 b=0xFF → f=0x0F, n=0, lt=eq=gt=0. Start pulsed again at RUN cycle 3 with different operands → ignored; result unchanged.
- Reset asserted at RUN cycle 4 → all outputs 0 immediately, state IDLE. A subsequent ADD 0x12+0x34 → f=0x46 after 8 cycles.
- Start held high across DONE → done pulses each 9 cycles and busy drops for exactly one cycle per operation.
